// File: rtl/achannel_rx_fifo_pkg.sv
// Shared constants for the RMI receive-path FIFO: message geometry and address byte offsets.
`timescale 1ns/1ps
package achannel_rx_fifo_pkg;
    localparam int SIZE_DATA        = 56;
    localparam int RMI_MSG_SIZE_DEF = SIZE_DATA + 24;
    localparam int LOG2_DEPTH_DEF   = 2;
    // Physical origin address bytes sit above the payload: X, then Y, then local on top.
    localparam int ADDR_X_LSB       = SIZE_DATA;
    localparam int ADDR_Y_LSB       = SIZE_DATA + 8;
    localparam int ADDR_LOCAL_LSB   = SIZE_DATA + 16;
endpackage

// File: rtl/achannel_fifo_mem.sv
// Simple dual-port message storage: registered write, combinational read, no reset.
`timescale 1ns/1ps
module achannel_fifo_mem
    import achannel_rx_fifo_pkg::*;
#(
    parameter int RMI_MSG_SIZE = RMI_MSG_SIZE_DEF,
    parameter int LOG2_DEPTH   = LOG2_DEPTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [LOG2_DEPTH-1:0]   waddr_i,
    input  logic [RMI_MSG_SIZE-1:0] wdata_i,
    input  logic [LOG2_DEPTH-1:0]   raddr_i,
    output logic [RMI_MSG_SIZE-1:0] rdata_o
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;

    logic [RMI_MSG_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/achannel_rx_fifo.sv
// Elastic buffer between the RTSNoC bridge rx achannel and an HLS component input achannel.
`timescale 1ns/1ps
module achannel_rx_fifo
    import achannel_rx_fifo_pkg::*;
#(
    parameter int RMI_MSG_SIZE = RMI_MSG_SIZE_DEF,
    parameter int LOG2_DEPTH   = LOG2_DEPTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [RMI_MSG_SIZE-1:0] br_z_i,
    input  logic                    br_vz_i,
    output logic                    br_lz_o,
    input  logic                    cmp_lz_i,
    output logic [RMI_MSG_SIZE-1:0] cmp_z_o,
    output logic                    cmp_vz_o,
    output logic [LOG2_DEPTH:0]     level_o,
    output logic                    overflow_o
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int LW    = LOG2_DEPTH + 1;

    logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    br_lz_q, br_lz_d;
    logic                    cmp_vz_q, cmp_vz_d;
    logic [RMI_MSG_SIZE-1:0] cmp_z_q, cmp_z_d;
    logic                    ovf_q, ovf_d;
    logic [RMI_MSG_SIZE-1:0] head;
    logic                    wr_acc;
    logic                    rd_fire;

    assign wr_acc  = br_vz_i & br_lz_q;
    // A request seen while a pulse is out belongs to the previous handshake.
    assign rd_fire = cmp_lz_i & ~cmp_vz_q & (level_q != '0);

    always_comb begin
        level_d  = level_q + LW'(wr_acc) - LW'(rd_fire);
        wr_ptr_d = wr_acc  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        br_lz_d  = (level_d < LW'(DEPTH));
        cmp_vz_d = rd_fire;
        cmp_z_d  = rd_fire ? head : cmp_z_q;
        ovf_d    = ovf_q | (br_vz_i & ~br_lz_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            br_lz_q  <= 1'b0;
            cmp_vz_q <= 1'b0;
            cmp_z_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            br_lz_q  <= br_lz_d;
            cmp_vz_q <= cmp_vz_d;
            cmp_z_q  <= cmp_z_d;
            ovf_q    <= ovf_d;
        end
    end

    achannel_fifo_mem #(
        .RMI_MSG_SIZE (RMI_MSG_SIZE),
        .LOG2_DEPTH   (LOG2_DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (br_z_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign br_lz_o    = br_lz_q;
    assign cmp_vz_o   = cmp_vz_q;
    assign cmp_z_o    = cmp_z_q;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_achannel_rx_fifo.sv
// Directed scenario bench for achannel_rx_fifo (DEPTH = 4).
`timescale 1ns/1ps
module tb_achannel_rx_fifo;
    localparam int W  = 80;
    localparam int LD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  br_z = '0;
    logic          br_vz = 1'b0;
    logic          br_lz;
    logic          cmp_lz = 1'b0;
    logic [W-1:0]  cmp_z;
    logic          cmp_vz;
    logic [LD:0]   level;
    logic          ovf;

    int tests_run = 0;
    int tests_failed = 0;

    achannel_rx_fifo #(.RMI_MSG_SIZE(W), .LOG2_DEPTH(LD)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .br_z_i     (br_z),
        .br_vz_i    (br_vz),
        .br_lz_o    (br_lz),
        .cmp_lz_i   (cmp_lz),
        .cmp_z_o    (cmp_z),
        .cmp_vz_o   (cmp_vz),
        .level_o    (level),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [7:0] v);
        return {24'h010002, 48'h0, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        br_vz = 1'b0; cmp_lz = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            br_vz = 1'b1; br_z = mk(base + 8'(i));
            step();
        end
        br_vz = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmp_lz = 1'b1;
        step(); step();
        tests_run++;
        if ({br_lz, cmp_vz, level, ovf} !== 6'b0 || cmp_z !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: br_lz=%b vz=%b level=%0d ovf=%b z=%h, want all 0", br_lz, cmp_vz, level, ovf, cmp_z);
        end
        rst_n = 1'b1;
        #2;
        tests_run++;
        if (br_lz !== 1'b0) begin
            tests_failed++;
            $display("FAIL lz_before_edge: got %b want 0", br_lz);
        end
        step();
        tests_run++;
        if (br_lz !== 1'b1 || level !== 3'd0) begin
            tests_failed++;
            $display("FAIL lz_after_release: br_lz=%b level=%0d want 1/0", br_lz, level);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (cmp_vz !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_no_pulse[%0d]: vz=%b want 0", i, cmp_vz);
            end
        end
        cmp_lz = 1'b0;
    endtask

    task automatic test_fill_drain();
        push4(8'h01);
        tests_run++;
        if (level !== 3'd4 || br_lz !== 1'b0) begin
            tests_failed++;
            $display("FAIL full: level=%0d br_lz=%b want 4/0", level, br_lz);
        end
        cmp_lz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (cmp_vz !== 1'b1 || cmp_z !== mk(8'(i + 1)) || level !== 3'(3 - i) || br_lz !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain[%0d]: vz=%b z=%h level=%0d lz=%b want 1 %h %0d 1", i, cmp_vz, cmp_z, level, br_lz, mk(8'(i + 1)), 3 - i);
            end
            step();
            tests_run++;
            if (cmp_vz !== 1'b0 || cmp_z !== mk(8'(i + 1))) begin
                tests_failed++;
                $display("FAIL drain_gap[%0d]: vz=%b z=%h want 0 %h", i, cmp_vz, cmp_z, mk(8'(i + 1)));
            end
        end
        cmp_lz = 1'b0;
        tests_run++;
        if (level !== 3'd0) begin
            tests_failed++;
            $display("FAIL drained_level: got %0d want 0", level);
        end
    endtask

    task automatic test_overflow();
        push4(8'h01);
        br_vz = 1'b1; br_z = mk(8'hFF);
        step();
        br_vz = 1'b0;
        tests_run++;
        if (ovf !== 1'b1 || level !== 3'd4) begin
            tests_failed++;
            $display("FAIL overflow_set: ovf=%b level=%0d want 1/4", ovf, level);
        end
        step(); step();
        tests_run++;
        if (ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_sticky: got %b want 1", ovf);
        end
        cmp_lz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (cmp_vz !== 1'b1 || cmp_z !== mk(8'(i + 1))) begin
                tests_failed++;
                $display("FAIL ovf_drain[%0d]: vz=%b z=%h want 1 %h", i, cmp_vz, cmp_z, mk(8'(i + 1)));
            end
            step();
        end
        step(); step();
        tests_run++;
        if (cmp_vz !== 1'b0 || level !== 3'd0 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_after: vz=%b level=%0d ovf=%b want 0 0 1", cmp_vz, level, ovf);
        end
        cmp_lz = 1'b0;
    endtask

    task automatic test_same_cycle();
        br_vz = 1'b1; br_z = mk(8'hAA);
        step();
        br_z = mk(8'hBB); cmp_lz = 1'b1;
        step();
        br_vz = 1'b0;
        tests_run++;
        if (cmp_vz !== 1'b1 || cmp_z !== mk(8'hAA) || level !== 3'd1) begin
            tests_failed++;
            $display("FAIL same_cycle: vz=%b z=%h level=%0d want 1 %h 1", cmp_vz, cmp_z, level, mk(8'hAA));
        end
        step();
        tests_run++;
        if (cmp_vz !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_gap: vz=%b want 0", cmp_vz);
        end
        step();
        tests_run++;
        if (cmp_vz !== 1'b1 || cmp_z !== mk(8'hBB) || level !== 3'd0) begin
            tests_failed++;
            $display("FAIL same_cycle_next: vz=%b z=%h level=%0d want 1 %h 0", cmp_vz, cmp_z, level, mk(8'hBB));
        end
        cmp_lz = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        int sent = 0;
        int got = 0;
        reset_dut();
        cmp_lz = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            if (sent < 10 && br_lz) begin
                br_vz = 1'b1; br_z = mk(8'h10 + 8'(sent));
                exp_q.push_back(mk(8'h10 + 8'(sent)));
                sent++;
            end else begin
                br_vz = 1'b0;
            end
            step();
            if (cmp_vz === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0 || cmp_z !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL stream[%0d]: got %h want %h", got, cmp_z, (exp_q.size() != 0) ? exp_q[0] : '0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
        end
        br_vz = 1'b0; cmp_lz = 1'b0;
        tests_run++;
        if (got !== 10 || ovf !== 1'b0 || level !== 3'd0) begin
            tests_failed++;
            $display("FAIL stream_end: delivered=%0d ovf=%b level=%0d want 10 0 0", got, ovf, level);
        end
    endtask

    task automatic test_reset_mid();
        push4(8'h31);
        br_vz = 1'b1; br_z = mk(8'hEE);
        step();
        br_vz = 1'b0; cmp_lz = 1'b1;
        step();
        cmp_lz = 1'b0;
        tests_run++;
        if (cmp_vz !== 1'b1 || level !== 3'd3 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_setup: vz=%b level=%0d ovf=%b want 1 3 1", cmp_vz, level, ovf);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (cmp_vz !== 1'b0 || br_lz !== 1'b0 || level !== 3'd0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: vz=%b lz=%b level=%0d ovf=%b want 0 0 0 0", cmp_vz, br_lz, level, ovf);
        end
        step();
        rst_n = 1'b1;
        step();
        br_vz = 1'b1; br_z = mk(8'h55);
        step();
        br_vz = 1'b0; cmp_lz = 1'b1;
        step();
        tests_run++;
        if (cmp_vz !== 1'b1 || cmp_z !== mk(8'h55) || level !== 3'd0) begin
            tests_failed++;
            $display("FAIL post_reset_read: vz=%b z=%h level=%0d want 1 %h 0", cmp_vz, cmp_z, level, mk(8'h55));
        end
        step(); step();
        tests_run++;
        if (cmp_vz !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_stale: vz=%b want 0", cmp_vz);
        end
        cmp_lz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
